conv_row_engine: RTL

- Parametrised, pipelined successor to the fixed 2x2, 4-output, single-channel conv row core.
- Accepts one K-row image strip plus a KxK filter per input channel over a valid/ready handshake.
- Computes N horizontally adjacent conv outputs and accumulates them across CH input channels.
- Emits one saturated result word per output pixel group; sits between the line-buffer/window feeder and the output writeback in the conv datapath.

---
 rtl/conv_row_engine.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/conv_row_engine.sv
// rtl/conv_row_engine.sv - pipelined KxK conv row engine, N outputs per beat, CH-channel accumulation
//
// Purpose: takes one K-row image strip (width W = K+N-1) and one KxK filter per
// beat, forms N horizontally adjacent conv sums, accumulates them over CH input
// channels and emits one saturated result group per CH beats.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   flush               synchronous abort of the partial group (pending output kept)
//   in_valid/in_ready   beat handshake for image + filter
//   image               pixel (r,c) at [DW*(r*W+c) +: DW], signed
//   filter              weight (r,c) at [DW*(r*K+c) +: DW], signed
//   out_valid/out_ready result group handshake
//   conv_out            result j at [OUT_W*j +: OUT_W], saturated signed
//   ch_idx              channel index of the next beat to be accepted
//
// Build option: define CONV_RELU_EN to clamp negative sums to zero before saturation.

module conv_row_engine #(
    parameter int K     = 2,
    parameter int N     = 4,
    parameter int CH    = 1,
    parameter int DW    = 8,
    parameter int OUT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DW*K*(K+N-1)-1:0]   image,
    input  logic [DW*K*K-1:0]         filter,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W*N-1:0]        conv_out,
    output logic [$clog2(CH):0]       ch_idx
);

    localparam int W     = K + N - 1;
    localparam int KK    = K * K;
    localparam int PW    = 2 * DW;
    localparam int ACC_W = 2 * DW + $clog2(K * K * CH) + 1;
    localparam int CH_W  = $clog2(CH) + 1;
    // Comparison width wide enough to hold both the accumulator and the output range.
    localparam int CW    = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

    localparam logic [CH_W-1:0]         CH_MAX  = CH_W'(CH - 1);
    localparam logic signed [CW-1:0]    SAT_MAX = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]        OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
`ifndef CONV_RELU_EN
    localparam logic signed [CW-1:0]    SAT_MIN = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0]        OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
`endif

    logic                    ready_q;
    logic                    adv;
    logic                    accept;
    logic                    ch_last;
    logic                    s1_valid;
    logic                    s1_last;
    logic                    s1_first;
    logic signed [PW-1:0]    prod  [N][KK];
    logic signed [ACC_W-1:0] acc   [N];
    logic signed [ACC_W-1:0] total [N];
    logic [OUT_W*N-1:0]      sat_out;

    // The whole pipeline moves only when the output register can take a new group.
    assign adv     = ~out_valid | out_ready;
    assign in_ready = adv & ~flush & ready_q;
    assign accept  = in_valid & in_ready;
    assign ch_last = (ch_idx == CH_MAX);

    // S1 products: datapath only, qualified by s1_valid, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int j = 0; j < N; j++) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K; c++) begin
                        prod[j][r*K+c] <= $signed(image[DW*(r*W+j+c) +: DW])
                                        * $signed(filter[DW*(r*K+c) +: DW]);
                    end
                end
            end
        end
    end

    // S2 combinational part: per-output adder tree, channel accumulate, clip.
    always_comb begin
        logic signed [ACC_W-1:0] s;
        logic signed [CW-1:0]    w;
        s       = '0;
        w       = '0;
        sat_out = '0;
        for (int j = 0; j < N; j++) begin
            total[j] = '0;
        end
        for (int j = 0; j < N; j++) begin
            s = s1_first ? '0 : acc[j];
            for (int i = 0; i < KK; i++) begin
                s = s + $signed({{(ACC_W-PW){prod[j][i][PW-1]}}, prod[j][i]});
            end
            total[j] = s;
            w = $signed({{(CW-ACC_W){s[ACC_W-1]}}, s});
`ifdef CONV_RELU_EN
            if (w < 0) begin
                w = '0;
            end
            if (w > SAT_MAX) begin
                sat_out[OUT_W*j +: OUT_W] = OUT_MAX;
            end else begin
                sat_out[OUT_W*j +: OUT_W] = w[OUT_W-1:0];
            end
`else
            if (w > SAT_MAX) begin
                sat_out[OUT_W*j +: OUT_W] = OUT_MAX;
            end else if (w < SAT_MIN) begin
                sat_out[OUT_W*j +: OUT_W] = OUT_MIN;
            end else begin
                sat_out[OUT_W*j +: OUT_W] = w[OUT_W-1:0];
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q   <= 1'b0;
            ch_idx    <= '0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_first  <= 1'b0;
            out_valid <= 1'b0;
            conv_out  <= '0;
            for (int j = 0; j < N; j++) begin
                acc[j] <= '0;
            end
        end else begin
            ready_q <= 1'b1;
            if (flush) begin
                ch_idx   <= '0;
                s1_valid <= 1'b0;
                for (int j = 0; j < N; j++) begin
                    acc[j] <= '0;
                end
            end else if (adv) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_last  <= ch_last;
                    s1_first <= (ch_idx == '0);
                    ch_idx   <= ch_last ? '0 : ch_idx + CH_W'(1);
                end
                if (s1_valid) begin
                    // Completing group clears the accumulators for the next one.
                    for (int j = 0; j < N; j++) begin
                        acc[j] <= s1_last ? '0 : total[j];
                    end
                    if (s1_last) begin
                        conv_out <= sat_out;
                    end
                end
            end

            // A completing group wins over the handshake so back-to-back groups stay valid.
            if (!flush && adv && s1_valid && s1_last) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
